tff_counter_ctrl: RTL

Controller for a WIDTH-bit synchronous counter built from T flip-flop stages. It accepts run, stop, and clear commands, latches a terminal value and a direction at start, and computes the per-stage toggle enables. It also signals terminal count and one-shot completion. The block owns the T-FF bank, sits between board-level control logic and the counter outputs, and replaces free-running counters wherever a counter must be started, paused, or bounded.

---
 rtl/tffc_pkg.sv | 13 +
 rtl/tff_stage.sv | 21 ++
 rtl/tff_counter_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/tffc_pkg.sv
// Shared types and constants for the T-FF counter controller.
package tffc_pkg;

  localparam int unsigned TFFC_WIDTH_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } tffc_state_e;

endpackage

// File: rtl/tff_stage.sv
// Single T flip-flop stage: toggles its output when t is high at the clock edge.
module tff_stage (
  input  logic clk,
  input  logic RSTN,
  input  logic t,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      r_q <= 1'b0;
    end else begin
      r_q <= r_q ^ t;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/tff_counter_ctrl.sv
// Run/stop/clear controller driving a bank of T flip-flops as a bounded up/down counter.
// Optional advance prescaler is compiled in with TFFC_PRESCALE_EN.
module tff_counter_ctrl
  import tffc_pkg::*;
#(
  parameter int unsigned WIDTH    = TFFC_WIDTH_DEFAULT,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             RSTN,
  input  logic             start,
  input  logic             stop,
  input  logic             clr,
  input  logic             up,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] t_en,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  tffc_state_e      r_state;
  tffc_state_e      w_state_nxt;
  logic             r_up;
  logic             r_oneshot;
  logic [WIDTH-1:0] r_lim;
  logic             r_tc;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_t_en;
  logic [WIDTH-1:0] w_strt;
  logic [WIDTH-1:0] w_term;
  logic             w_tc_nxt;
  logic             w_latch;
  logic             w_tick;

  // A zero prescale has no meaningful tick rate; nothing is generated for it.
  if (PRESCALE == 0) begin : g_prescale_zero_unsupported
  end

`ifdef TFFC_PRESCALE_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] r_pre;
  logic [PW-1:0] w_pre_nxt;

  assign w_tick = (r_pre == PW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      r_pre <= '0;
    end else begin
      r_pre <= w_pre_nxt;
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  // Start and terminal values come from the fields latched at the last fresh start.
  assign w_strt = r_up ? '0 : r_lim;
  assign w_term = r_up ? r_lim : '0;

  // Next state and next count; priority is clr, then stop, then start.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_q;
    w_tc_nxt    = 1'b0;
    w_latch     = 1'b0;
`ifdef TFFC_PRESCALE_EN
    w_pre_nxt   = r_pre;
`endif
    if (clr) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
`ifdef TFFC_PRESCALE_EN
      w_pre_nxt   = '0;
`endif
    end else if (stop) begin
      if (r_state == RUN) begin
        w_state_nxt = HOLD;
      end
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            w_state_nxt = RUN;
            w_latch     = 1'b1;
            w_cnt_nxt   = up ? '0 : limit;
`ifdef TFFC_PRESCALE_EN
            w_pre_nxt   = '0;
`endif
          end
        end
        HOLD: begin
          if (start) begin
            w_state_nxt = RUN;
          end
        end
        RUN: begin
`ifdef TFFC_PRESCALE_EN
          w_pre_nxt = w_tick ? '0 : r_pre + PW'(1);
`endif
          if (w_tick) begin
            if (w_q == w_term) begin
              w_tc_nxt = 1'b1;
              if (r_oneshot) begin
                w_state_nxt = DONE;
              end else begin
                w_cnt_nxt = w_strt;
              end
            end else begin
              w_cnt_nxt = r_up ? w_q + WIDTH'(1) : w_q - WIDTH'(1);
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // Every count change, including load and clear, is expressed as stage toggles.
  assign w_t_en = w_q ^ w_cnt_nxt;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
    tff_stage u_stage (
      .clk  (clk),
      .RSTN (RSTN),
      .t    (w_t_en[gi]),
      .q    (w_q[gi])
    );
  end

  // State register, latched run parameters and registered status outputs.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      r_state   <= IDLE;
      r_up      <= 1'b0;
      r_oneshot <= 1'b0;
      r_lim     <= '0;
      r_tc      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tc    <= w_tc_nxt;
      r_busy  <= (w_state_nxt == RUN);
      r_done  <= (w_state_nxt == DONE);
      if (w_latch) begin
        r_up      <= up;
        r_oneshot <= oneshot;
        r_lim     <= limit;
      end
    end
  end

  assign count = w_q;
  assign t_en  = w_t_en;
  assign busy  = r_busy;
  assign tc    = r_tc;
  assign done  = r_done;

endmodule
